alu_checker: RTL
================

# alu_checker

Synthesizable self-checking driver for the `alu` block. On a start pulse it sweeps every operation (add, sub, and, or, xor) across the full `a`/`b` operand space and drives `mux`/`a`/`b`/`ci` into an `alu` instance. It compares the ALU's `y`/`co` against an internal golden model and reports an error count plus the first failing vector. It sits beside `alu` in on-chip BIST and in board bring-up builds.

## Interface

Parameters:
- `W`, 4: ALU operand width.
- `SETTLE`, 0: extra hold cycles per vector before comparison.
- `CW`, 16: error counter width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a sweep from IDLE or DONE.
- `mux` out 3: ALU operation select; encodings in Operation.
- `a` out W: ALU operand a.
- `b` out W: ALU operand b.
- `ci` out 1: ALU carry-in.
- `y` in W: ALU result.
- `co` in 1: ALU carry-out.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: `done && err_cnt == 0`.
- `err_cnt` out CW: saturating mismatch count.
- `fail_mux` out 3: op select of the first mismatch.
- `fail_a` out W: operand a of the first mismatch.
- `fail_b` out W: operand b of the first mismatch.

## Operation

- Op encodings:
  - ADD 3'b000, ci=0, expected `{co,y} = a+b`.
  - SUB 3'b100, ci=1, expected `{co,y} = a + ~b + 1` (co=1 means no borrow).
  - AND 3'b001, ci=0.
  - OR 3'b010, ci=0.
  - XOR 3'b011, ci=0.
  - For logic ops `co` is don't-care; only `y` is compared.
- FSM states:
  - IDLE: `start` -> RUN.
  - RUN: last compare of the last vector -> DONE.
  - DONE: `start` -> RUN.
- `start` during RUN is ignored.
- Sweep order: ops ADD, SUB, AND, OR, XOR. Within each op, index `i` runs 0..2^(2W)-1, with `a = i[W-1:0]` and `b = i[2W-1:W]`.
- Entry to RUN:
  - Clears `err_cnt`, `fail_*`, and the first-fail flag.
  - Loads vector 0 of ADD.
- Each vector is held for 1+SETTLE cycles. On the clock edge that ends the last hold cycle:
  - Compare `y`/`co` against the golden model for the currently driven `mux`/`a`/`b`/`ci`.
  - On mismatch, `err_cnt` increments, saturating at 2^CW-1.
  - On the first mismatch of a sweep, `fail_*` capture the driven vector.
  - Advance to the next vector.
- Index wrap at 2^(2W)-1 advances the op. Wrap after XOR enters DONE.
- Outputs hold in DONE until the next `start`: `err_cnt`, `fail_*`, and last driven `mux`/`a`/`b`/`ci`.
- Reset values:
  - State IDLE.
  - `mux`=000, `a`=0, `b`=0, `ci`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `err_cnt`=0, `fail_*`=0.
- Reset mid-sweep aborts immediately to the reset values. No partial result is retained.

## Timing

- All outputs are registered. `alu` is combinational between `a`/`b`/`mux`/`ci` and `y`/`co`.
- `start` sampled high at edge 0:
  - `busy`=1 and vector 0 driven from edge 1.
  - First compare at edge 2+SETTLE.
- Sweep length is `5 * 2^(2W) * (1+SETTLE)` cycles.
- `done` rises on the edge of the final compare, so `busy` falls in the same cycle `done` rises.
- `err_cnt` and `fail_*` are updated on the compare edge and are visible the following cycle.
- A mismatch on the final vector is counted before `done` rises.

## Structure

- Package `alu_pkg`:
  - Op encoding constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`.
  - Per-op `ci` constants.
  - FSM state typedef `alu_chk_state_t`.
- Sub-module `alu_model`: combinational golden model with inputs `mux`/`a`/`b`/`ci`, outputs `y`/`co`, and a `co_valid` flag (0 for logic ops).
- `alu_checker` holds the FSM, the vector counter, the settle counter, the error counter, and the first-fail capture.

## Test plan

- Real `alu`, W=4, SETTLE=0, `start` at cycle 10 -> `busy` cycles 11..1290; `done`=1, `pass`=1 and `err_cnt`=0 at cycle 1291.
- Fault injection: `y` inverted only when mux=011, a=3, b=5 -> `err_cnt`=1, `fail_mux`=011, `fail_a`=3, `fail_b`=5, `pass`=0.
- `co` forced to 0 in SUB -> `err_cnt`=136, `fail_mux`=100, `fail_a`=0, `fail_b`=0 (136 = SUB vectors with a >= b; first hit is a=0, b=0).
- `y` tied to 0 with CW=4 -> `err_cnt` saturates at 15. `fail_*` = ADD, a=1, b=0 (first vector with nonzero sum).
- `rst_n` low at cycle 500 mid-sweep -> all outputs at reset values next cycle. A new `start` runs the full sweep; no stale `err_cnt`.
- `start` pulses at cycles 100 and 600 during RUN -> ignored; sweep length unchanged. `start` in DONE -> new sweep with cleared counters. SETTLE=2 -> sweep length 3840 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, per-op carry-in and checker FSM states
// for the alu BIST driver (alu_checker) and its golden model (alu_model).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

  localparam logic CI_ADD = 1'b0;
  localparam logic CI_SUB = 1'b1;
  localparam logic CI_AND = 1'b0;
  localparam logic CI_OR  = 1'b0;
  localparam logic CI_XOR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_chk_state_t;

  // Sweep order: ADD, SUB, AND, OR, XOR
  function automatic logic [2:0] op_next(input logic [2:0] m);
    logic [2:0] r;
    r = OP_ADD;
    unique case (1'b1)
      (m == OP_ADD): r = OP_SUB;
      (m == OP_SUB): r = OP_AND;
      (m == OP_AND): r = OP_OR;
      (m == OP_OR):  r = OP_XOR;
      default:       r = OP_ADD;
    endcase
    return r;
  endfunction

  function automatic logic op_ci(input logic [2:0] m);
    logic r;
    r = CI_ADD;
    unique case (1'b1)
      (m == OP_SUB): r = CI_SUB;
      (m == OP_AND): r = CI_AND;
      (m == OP_OR):  r = CI_OR;
      (m == OP_XOR): r = CI_XOR;
      default:       r = CI_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_checker_model.sv
// alu_model: combinational golden ALU. in: mux, a, b, ci.
// out: y, co, co_valid (co is only meaningful for ADD/SUB).
module alu_model
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   mux,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] y,
  output logic         co,
  output logic         co_valid
);

  logic [W:0] w_sum;
  logic [W:0] w_dif;

  assign w_sum = {1'b0, a} + {1'b0, b}
               + {{W{1'b0}}, ci};
  // co=1 on SUB means no borrow
  assign w_dif = {1'b0, a} + {1'b0, ~b}
               + {{W{1'b0}}, ci};

  always_comb begin
    y        = '0;
    co       = 1'b0;
    co_valid = 1'b0;
    unique case (1'b1)
      (mux == OP_ADD): begin
        {co, y}  = w_sum;
        co_valid = 1'b1;
      end
      (mux == OP_SUB): begin
        {co, y}  = w_dif;
        co_valid = 1'b1;
      end
      (mux == OP_AND): y = a & b;
      (mux == OP_OR):  y = a | b;
      (mux == OP_XOR): y = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_checker.sv
// alu_checker: sweeps all ops x all a/b into an external alu and checks
// y/co against alu_model. in: clk, rst_n, start, y, co. out: mux, a, b, ci,
// busy, done, pass, err_cnt, fail_mux/a/b (first mismatching vector).
module alu_checker
  import alu_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [2:0]    mux,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          ci,
  input  logic [W-1:0]  y,
  input  logic          co,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [2:0]    fail_mux,
  output logic [W-1:0]  fail_a,
  output logic [W-1:0]  fail_b
);

  localparam int SW =
    (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

  alu_chk_state_t r_state;
  alu_chk_state_t w_nxt;

  logic            r_start;
  logic [2*W-1:0]  r_idx;
  logic [2:0]      r_mux;
  logic            r_ci;
  logic [SW-1:0]   r_settle;
  logic [CW-1:0]   r_err;
  logic            r_ffail;
  logic [2:0]      r_fmux;
  logic [W-1:0]    r_fa;
  logic [W-1:0]    r_fb;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic [W-1:0]    w_ey;
  logic            w_eco;
  logic            w_cov;
  logic            w_launch;
  logic            w_cmp;
  logic            w_idx_end;
  logic            w_last;
  logic            w_mis;
  logic [CW-1:0]   w_err_nxt;

  alu_model #(.W(W)) u_model (
    .mux      (r_mux),
    .a        (r_idx[W-1:0]),
    .b        (r_idx[2*W-1:W]),
    .ci       (r_ci),
    .y        (w_ey),
    .co       (w_eco),
    .co_valid (w_cov)
  );

  // start is registered once, so vector 0 appears one edge after it
  assign w_launch  = r_start && (r_state != ST_RUN);
  assign w_cmp     = (r_state == ST_RUN)
                  && (r_settle == SETTLE_V);
  assign w_idx_end = &r_idx;
  assign w_last    = w_cmp && w_idx_end
                  && (r_mux == OP_XOR);
  assign w_mis     = (y != w_ey)
                  || (w_cov && (co != w_eco));

  always_comb begin
    w_err_nxt = r_err;
    if (w_launch)
      w_err_nxt = '0;
    else if (w_cmp && w_mis && (r_err != '1))
      w_err_nxt = r_err + CW'(1);
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (r_start) w_nxt = ST_RUN;
      ST_RUN:  if (w_last)  w_nxt = ST_DONE;
      ST_DONE: if (r_start) w_nxt = ST_RUN;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start  <= 1'b0;
      r_idx    <= '0;
      r_mux    <= OP_ADD;
      r_ci     <= CI_ADD;
      r_settle <= '0;
      r_err    <= '0;
      r_ffail  <= 1'b0;
      r_fmux   <= '0;
      r_fa     <= '0;
      r_fb     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_start <= start;
      r_err   <= w_err_nxt;
      r_busy  <= (w_nxt == ST_RUN);
      r_done  <= (w_nxt == ST_DONE);
      r_pass  <= (w_nxt == ST_DONE)
              && (w_err_nxt == '0);
      if (w_launch) begin
        r_idx    <= '0;
        r_mux    <= OP_ADD;
        r_ci     <= CI_ADD;
        r_settle <= '0;
        r_ffail  <= 1'b0;
        r_fmux   <= '0;
        r_fa     <= '0;
        r_fb     <= '0;
      end else if (w_cmp) begin
        r_settle <= '0;
        if (w_mis && !r_ffail) begin
          r_ffail <= 1'b1;
          r_fmux  <= r_mux;
          r_fa    <= r_idx[W-1:0];
          r_fb    <= r_idx[2*W-1:W];
        end
        // final vector stays driven through DONE
        if (!w_last) begin
          r_idx <= r_idx + (2*W)'(1);
          if (w_idx_end) begin
            r_mux <= op_next(r_mux);
            r_ci  <= op_ci(op_next(r_mux));
          end
        end
      end else if (r_state == ST_RUN) begin
        r_settle <= r_settle + SW'(1);
      end
    end
  end

  assign mux      = r_mux;
  assign a        = r_idx[W-1:0];
  assign b        = r_idx[2*W-1:W];
  assign ci       = r_ci;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_mux = r_fmux;
  assign fail_a   = r_fa;
  assign fail_b   = r_fb;

endmodule
